// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bundle for the register-file write arbiter.
// Packed per-requester valid/addr/data plus the one-hot ready.
interface regfile_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
);
  logic [NREQ-1:0]       req;
  logic [NREQ*5-1:0]     req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ready;

  modport master (
    output req,
    output req_addr,
    output req_data,
    input  ready
  );

  modport slave (
    input  req,
    input  req_addr,
    input  req_data,
    output ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Winner is registered; X31 writes are accepted but never enabled.
module regfile_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  regfile_wr_arbiter_if.slave     rq,
  output logic                    we,
  output logic [4:0]              wa,
  output logic [WIDTH-1:0]        wd,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   g;
  logic [PW:0]     idx;
  logic            hit;
  logic            xfer;
  logic            xzr_q;
  logic [NREQ-1:0] gnt_oh;
  logic [4:0]      sel_addr;
  logic [WIDTH-1:0] sel_data;

  // Scan from ptr upward (mod NREQ) for the first active request.
  always_comb begin
    hit = 1'b0;
    g   = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (!hit && rq.req[idx[PW-1:0]]) begin
        hit = 1'b1;
        g   = idx[PW-1:0];
      end
    end
  end

  // Grant, winner payload mux, next pointer and next state.
  always_comb begin
    gnt_oh   = '0;
    sel_addr = '0;
    sel_data = '0;
    if (hit && !stall && reset)
      gnt_oh[g] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (g == PW'(i)) begin
        sel_addr = rq.req_addr[5*i +: 5];
        sel_data = rq.req_data[WIDTH*i +: WIDTH];
      end
    end
    xfer    = |(rq.req & gnt_oh);
    ptr_d   = (g == PW'(NREQ-1)) ? '0 : g + 1'b1;
    state_d = xfer ? WRITE : IDLE;
  end

  assign rq.ready = gnt_oh;

  // WRITE only after a transfer; X31 captures still block the enable.
  assign we = (state_q == WRITE) && !xzr_q;

  // State register and captured write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      xzr_q   <= 1'b0;
      ptr_q   <= '0;
      wa      <= '0;
      wd      <= '0;
      gnt_id  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        xzr_q  <= (sel_addr == 5'd31);
        ptr_q  <= ptr_d;
        wa     <= sel_addr;
        wd     <= sel_data;
        gnt_id <= g;
      end
    end
  end

endmodule
